// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and decoded command/error outputs of the UART command parser.
// The master side feeds received bytes; the slave side is the parser itself.
interface uart_cmd_parser_if #(
  parameter int MAX_LEN = 4
);
  logic [7:0]           rx_data;
  logic                 rx_done;
  logic                 rx_en;
  logic                 cmd_valid;
  logic [7:0]           cmd_code;
  logic [3:0]           cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic                 err_valid;
  logic [1:0]           err_code;
  logic [7:0]           err_cnt;

  modport master (
    output rx_data, rx_done,
    input  rx_en, cmd_valid, cmd_code, cmd_len, cmd_payload,
           err_valid, err_code, err_cnt
  );

  modport slave (
    input  rx_data, rx_done,
    output rx_en, cmd_valid, cmd_code, cmd_len, cmd_payload,
           err_valid, err_code, err_cnt
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles HDR/CMD/LEN/payload/CHK frames from the UART byte stream, validates
// length, checksum and inter-byte timing, and publishes accepted commands.
module uart_cmd_parser #(
  parameter logic [7:0] HDR         = 8'hA5,
  parameter int         MAX_LEN     = 4,
  parameter int         TIMEOUT_CYC = 491520
) (
  input logic              clk,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic [7:0]           sum;
  logic [7:0]           sh_code;
  logic [3:0]           sh_len;
  logic [8*MAX_LEN-1:0] sh_payload;
  logic [3:0]           idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      timer           <= '0;
      sum             <= '0;
      sh_code         <= '0;
      sh_len          <= '0;
      sh_payload      <= '0;
      idx             <= '0;
      bus.rx_en       <= 1'b0;
      bus.cmd_valid   <= 1'b0;
      bus.cmd_code    <= '0;
      bus.cmd_len     <= '0;
      bus.cmd_payload <= '0;
      bus.err_valid   <= 1'b0;
      bus.err_code    <= '0;
      bus.err_cnt     <= '0;
    end else begin
      bus.rx_en     <= ~bus.rx_done;
      bus.cmd_valid <= 1'b0;
      bus.err_valid <= 1'b0;

      if (bus.rx_done) begin
        // A byte arriving on the timeout cycle still counts; it restarts the timer.
        timer <= '0;
        case (state)
          S_IDLE: begin
            if (bus.rx_data == HDR) state <= S_CMD;
          end
          S_CMD: begin
            sh_code <= bus.rx_data;
            sum     <= bus.rx_data;
            state   <= S_LEN;
          end
          S_LEN: begin
            if (bus.rx_data > 8'(MAX_LEN)) begin
              bus.err_valid <= 1'b1;
              bus.err_code  <= 2'd2;
              bus.err_cnt   <= (bus.err_cnt == 8'hFF) ? bus.err_cnt : bus.err_cnt + 8'd1;
              state         <= S_IDLE;
            end else begin
              // Cleared for zero-length frames too so unused payload bytes read 0.
              sh_len     <= bus.rx_data[3:0];
              sum        <= sum + bus.rx_data;
              sh_payload <= '0;
              idx        <= '0;
              state      <= (bus.rx_data == 8'd0) ? S_CHK : S_DATA;
            end
          end
          S_DATA: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) sh_payload[8*i +: 8] <= bus.rx_data;
            end
            sum <= sum + bus.rx_data;
            idx <= idx + 4'd1;
            if (idx + 4'd1 == sh_len) state <= S_CHK;
          end
          S_CHK: begin
            if (bus.rx_data == sum) begin
              bus.cmd_valid   <= 1'b1;
              bus.cmd_code    <= sh_code;
              bus.cmd_len     <= sh_len;
              bus.cmd_payload <= sh_payload;
            end else begin
              bus.err_valid <= 1'b1;
              bus.err_code  <= 2'd3;
              bus.err_cnt   <= (bus.err_cnt == 8'hFF) ? bus.err_cnt : bus.err_cnt + 8'd1;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state == S_IDLE) begin
        timer <= '0;
      end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
        bus.err_valid <= 1'b1;
        bus.err_code  <= 2'd1;
        bus.err_cnt   <= (bus.err_cnt == 8'hFF) ? bus.err_cnt : bus.err_cnt + 8'd1;
        timer         <= '0;
        state         <= S_IDLE;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames plus random framed traffic,
// with expected command/error events queued by a frame-level reference model.
module tb_uart_cmd_parser;
  localparam int MAX_LEN = 4;
  localparam int TO      = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_cmd_parser #(
    .HDR(8'hA5),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit         is_err;
    bit         timed;
    logic [1:0] ecode;
    logic [7:0] ecnt;
    logic [7:0] code;
    logic [3:0] len;
    logic [31:0] pay;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  m_code = 0;
  logic [3:0]  m_len  = 0;
  logic [31:0] m_pay  = 0;
  logic [1:0]  m_ecode = 0;
  int          m_ecnt = 0;
  time         t_last, t_to;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_event(input bit is_err, input bit timed);
    exp_t e;
    e.is_err = is_err;
    e.timed  = timed;
    e.ecode  = m_ecode;
    e.ecnt   = 8'(m_ecnt);
    e.code   = m_code;
    e.len    = m_len;
    e.pay    = m_pay;
    q.push_back(e);
  endtask

  task automatic push_cmd(input logic [7:0] code, input int len, input logic [31:0] pay);
    m_code = code;
    m_len  = 4'(len);
    m_pay  = pay;
    push_event(1'b0, 1'b0);
  endtask

  task automatic push_err(input logic [1:0] c, input bit timed);
    m_ecode = c;
    if (m_ecnt < 255) m_ecnt++;
    push_event(1'b1, timed);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk);
    t_last = $time;
    #1 bus.rx_done = 1'b0;
    check("rx_en_after_done", 32'(bus.rx_en), 32'd0);
    repeat (gap) @(posedge clk);
    if (gap > 0) begin
      #1;
      check("rx_en_idle", 32'(bus.rx_en), 32'd1);
    end
  endtask

  task automatic send_bytes(input logic [7:0] bq[$]);
    foreach (bq[i]) send(bq[i], 0);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int len, input bit bad, input int maxgap);
    int s;
    logic [31:0] pay;
    logic [7:0] chk, b;
    s   = int'(cmd) + len;
    pay = 0;
    send(8'hA5, $urandom_range(0, maxgap));
    send(cmd, $urandom_range(0, maxgap));
    if (len > MAX_LEN) begin
      push_err(2'd2, 1'b0);
      send(8'(len), $urandom_range(0, maxgap));
      return;
    end
    send(8'(len), $urandom_range(0, maxgap));
    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom);
      s   = s + int'(b);
      pay = pay | (32'(b) << (8 * i));
      send(b, $urandom_range(0, maxgap));
    end
    chk = 8'(s % 256);
    if (bad) begin
      chk = chk + 8'($urandom_range(1, 255));
      push_err(2'd3, 1'b0);
    end else begin
      push_cmd(cmd, len, pay);
    end
    send(chk, $urandom_range(0, maxgap));
  endtask

  task automatic check_reset_vals();
    check("rst_rx_en", 32'(bus.rx_en), 32'd0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_cmd_code", 32'(bus.cmd_code), 32'd0);
    check("rst_cmd_len", 32'(bus.cmd_len), 32'd0);
    check("rst_cmd_payload", bus.cmd_payload, 32'd0);
    check("rst_err_valid", 32'(bus.err_valid), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
  endtask

  // Monitor: every output strobe must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && (bus.cmd_valid || bus.err_valid)) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_output: cmd_valid=%0b err_valid=%0b err_code=%0d expected none",
                   bus.cmd_valid, bus.err_valid, bus.err_code);
        end else begin
          e_mon = q.pop_front();
          check("err_valid", 32'(bus.err_valid), 32'(e_mon.is_err));
          check("cmd_valid", 32'(bus.cmd_valid), 32'(!e_mon.is_err));
          check("err_code", 32'(bus.err_code), 32'(e_mon.ecode));
          check("err_cnt", 32'(bus.err_cnt), 32'(e_mon.ecnt));
          check("cmd_code", 32'(bus.cmd_code), 32'(e_mon.code));
          check("cmd_len", 32'(bus.cmd_len), 32'(e_mon.len));
          check("cmd_payload", bus.cmd_payload, e_mon.pay);
          if (e_mon.timed) check("timeout_cycles", 32'(($time - t_to - 5) / 10), 32'(TO));
        end
      end
    end
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    reset = 1'b0;
    @(posedge clk);
    #1 check("rx_en_after_reset", 32'(bus.rx_en), 32'd1);

    // Basic two-byte payload
    send_bytes({8'hA5, 8'h10, 8'h02, 8'h34, 8'h12, 8'h58});
    push_cmd(8'h10, 2, 32'h0000_1234);

    // Zero-length frame, then a checksum error that must not disturb cmd_*
    send_bytes({8'hA5, 8'h20, 8'h00, 8'h20});
    push_cmd(8'h20, 0, 32'h0);
    send_bytes({8'hA5, 8'h10, 8'h02, 8'h34, 8'h12, 8'h00});
    push_err(2'd3, 1'b0);

    // Oversize length; trailing bytes are idle-state garbage
    send_bytes({8'hA5, 8'h30, 8'h05});
    push_err(2'd2, 1'b0);
    send_bytes({8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    send_bytes({8'hA5, 8'h11, 8'h01, 8'h22, 8'h34});
    push_cmd(8'h11, 1, 32'h22);

    // Inter-byte timeout
    send(8'hA5, 0);
    send(8'h40, 0);
    t_to = t_last;
    push_err(2'd1, 1'b1);
    repeat (TO + 5) @(posedge clk);
    #1;
    send_bytes({8'hA5, 8'h40, 8'h00, 8'h40});
    push_cmd(8'h40, 0, 32'h0);

    // Byte landing on the timeout cycle wins
    send(8'hA5, 0);
    send(8'h41, TO - 1);
    send(8'h00, TO - 1);
    send(8'h41, 0);
    push_cmd(8'h41, 0, 32'h0);

    // Leading garbage, header value as payload
    send_bytes({8'h00, 8'hFF, 8'hA5, 8'h50, 8'h01, 8'hA5, 8'hF6});
    push_cmd(8'h50, 1, 32'hA5);

    // Random framed traffic
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send(b, $urandom_range(0, 3));
      end
      send_frame(8'($urandom), $urandom_range(0, MAX_LEN + 2), ($urandom_range(0, 3) == 0), 3);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-frame
    send_bytes({8'hA5, 8'h60, 8'h01});
    reset = 1'b1;
    #2 check_reset_vals();
    m_code = 0; m_len = 0; m_pay = 0; m_ecode = 0; m_ecnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    send_bytes({8'hA5, 8'h60, 8'h01, 8'h07, 8'h68});
    push_cmd(8'h60, 1, 32'h07);

    // Error counter saturation
    for (int k = 0; k < 300; k++) begin
      send_bytes({8'hA5, 8'hC0, 8'h00, 8'h00});
      push_err(2'd3, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1 check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
